// File: rtl/data_cache_pkg.sv
// Shared definitions for the L1 data cache: FSM states, address field positions
// and the block word-merge helper.
package data_cache_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2
    } state_t;

    localparam int BLOCK_WORDS = 2;
    localparam int WORD_BIT    = 2;
    localparam int INDEX_LSB   = 3;
    localparam int BLOCK_BITS  = 32 * BLOCK_WORDS;

    // Replace one 32-bit word of a block; word 0 lives in the low half.
    function automatic logic [BLOCK_BITS-1:0] merge_word(
        input logic [BLOCK_BITS-1:0] blk,
        input logic                  sel,
        input logic [31:0]           word
    );
        logic [BLOCK_BITS-1:0] res;
        res = blk;
        if (sel) begin
            res[63:32] = word;
        end else begin
            res[31:0] = word;
        end
        return res;
    endfunction

endpackage

// File: rtl/data_cache_array.sv
// Valid/tag/data storage for the direct-mapped cache: combinational read,
// one full-line write port, valid bits cleared asynchronously on reset.
module data_cache_array
    import data_cache_pkg::*;
#(
    parameter int NUM_SETS   = 8,
    parameter int INDEX_BITS = 3,
    parameter int TAG_BITS   = 26
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INDEX_BITS-1:0] rd_index,
    output logic                  rd_valid,
    output logic [TAG_BITS-1:0]   rd_tag,
    output logic [BLOCK_BITS-1:0] rd_data,
    input  logic                  wr_en,
    input  logic [INDEX_BITS-1:0] wr_index,
    input  logic [TAG_BITS-1:0]   wr_tag,
    input  logic [BLOCK_BITS-1:0] wr_data
);

    logic [NUM_SETS-1:0]   valid;
    logic [TAG_BITS-1:0]   tags  [NUM_SETS];
    logic [BLOCK_BITS-1:0] lines [NUM_SETS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_index] <= 1'b1;
        end
    end

    // Tag and data need no reset: they are meaningless while valid is clear.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tags[wr_index]  <= wr_tag;
            lines[wr_index] <= wr_data;
        end
    end

    assign rd_valid = valid[rd_index];
    assign rd_tag   = tags[rd_index];
    assign rd_data  = lines[rd_index];

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-through, write-allocate L1 data cache with a 2-word block
// fill handshake (ReadMiss/ReadReady) and write-through handshake (MemWriteThrough/WriteReady).
module data_cache
    import data_cache_pkg::*;
#(
    parameter int NUM_SETS   = 8,
    parameter int INDEX_BITS = 3
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic [31:0]           Address,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [31:0]           Write_data,
    output logic [31:0]           Read_data,
    output logic                  Stall,
    output logic [31:0]           Mem_Address,
    output logic [BLOCK_BITS-1:0] Mem_Write_data,
    input  logic [BLOCK_BITS-1:0] Mem_Read_data,
    output logic                  ReadMiss,
    input  logic                  ReadReady,
    output logic                  MemWriteThrough,
    input  logic                  WriteReady
);

    localparam int TAG_LSB  = INDEX_LSB + INDEX_BITS;
    localparam int TAG_BITS = 32 - TAG_LSB;

    state_t state, state_next;

    logic [31:2]           req_addr;
    logic [31:0]           req_wdata;
    logic                  req_write;

    logic [INDEX_BITS-1:0] live_index, req_index;
    logic [TAG_BITS-1:0]   live_tag, req_tag;

    logic                  line_valid;
    logic [TAG_BITS-1:0]   line_tag;
    logic [BLOCK_BITS-1:0] line_data;
    logic                  hit;

    logic                  wr_en;
    logic [INDEX_BITS-1:0] wr_index;
    logic [TAG_BITS-1:0]   wr_tag;
    logic [BLOCK_BITS-1:0] wr_data;

    logic [BLOCK_BITS-1:0] hit_merged, fill_merged;
    logic                  read_miss_next, write_through_next;
    logic [BLOCK_BITS-1:0] mem_wdata_next;

    logic                  unused_bits;

    assign live_index = Address[TAG_LSB-1:INDEX_LSB];
    assign live_tag   = Address[31:TAG_LSB];
    assign req_index  = req_addr[TAG_LSB-1:INDEX_LSB];
    assign req_tag    = req_addr[31:TAG_LSB];
    assign unused_bits = ^Address[1:0];

    data_cache_array #(
        .NUM_SETS   (NUM_SETS),
        .INDEX_BITS (INDEX_BITS),
        .TAG_BITS   (TAG_BITS)
    ) u_array (
        .clk      (Clk),
        .rst      (Rst),
        .rd_index (live_index),
        .rd_valid (line_valid),
        .rd_tag   (line_tag),
        .rd_data  (line_data),
        .wr_en    (wr_en),
        .wr_index (wr_index),
        .wr_tag   (wr_tag),
        .wr_data  (wr_data)
    );

    assign hit       = line_valid && (line_tag == live_tag);
    assign Read_data = !hit ? 32'h0 :
                       (Address[WORD_BIT] ? line_data[63:32] : line_data[31:0]);

    assign hit_merged  = merge_word(line_data, Address[WORD_BIT], Write_data);
    assign fill_merged = merge_word(Mem_Read_data, req_addr[WORD_BIT], req_wdata);

    // While a transaction is outstanding the memory sees the request latched at IDLE exit.
    assign Mem_Address = (state == IDLE) ? {Address[31:INDEX_LSB], 3'b000}
                                         : {req_addr[31:INDEX_LSB], 3'b000};

    always_ff @(posedge Clk) begin
        if (state == IDLE) begin
            req_addr  <= Address[31:2];
            req_wdata <= Write_data;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state           <= IDLE;
            req_write       <= 1'b0;
            ReadMiss        <= 1'b0;
            MemWriteThrough <= 1'b0;
            Mem_Write_data  <= '0;
        end else begin
            state           <= state_next;
            ReadMiss        <= read_miss_next;
            MemWriteThrough <= write_through_next;
            Mem_Write_data  <= mem_wdata_next;
            if (state == IDLE) begin
                req_write <= MemWrite;
            end
        end
    end

    always_comb begin
        state_next         = state;
        Stall              = 1'b0;
        wr_en              = 1'b0;
        wr_index           = req_index;
        wr_tag             = req_tag;
        wr_data            = Mem_Read_data;
        read_miss_next     = ReadMiss;
        write_through_next = MemWriteThrough;
        mem_wdata_next     = Mem_Write_data;

        case (state)
            IDLE: begin
                if (MemWrite) begin
                    Stall = 1'b1;
                    if (hit) begin
                        wr_en              = 1'b1;
                        wr_index           = live_index;
                        wr_tag             = live_tag;
                        wr_data            = hit_merged;
                        mem_wdata_next     = hit_merged;
                        write_through_next = 1'b1;
                        state_next         = WRITE;
                    end else begin
                        read_miss_next = 1'b1;
                        state_next     = FILL;
                    end
                end else if (MemRead && !hit) begin
                    Stall          = 1'b1;
                    read_miss_next = 1'b1;
                    state_next     = FILL;
                end
            end

            FILL: begin
                Stall = 1'b1;
                if (ReadReady) begin
                    wr_en          = 1'b1;
                    read_miss_next = 1'b0;
                    if (req_write) begin
                        wr_data            = fill_merged;
                        mem_wdata_next     = fill_merged;
                        write_through_next = 1'b1;
                        state_next         = WRITE;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end

            WRITE: begin
                // Release the pipeline on the completing edge itself.
                Stall = ~WriteReady;
                if (WriteReady) begin
                    write_through_next = 1'b0;
                    state_next         = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_data_cache.sv
// Directed bench for data_cache: the bench plays the memory side of both
// handshakes from a 64-word model whose word n starts at n.
module tb_data_cache;

    logic        clk;
    logic        rst;
    logic [31:0] address;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        stall;
    logic [31:0] mem_address;
    logic [63:0] mem_write_data;
    logic [63:0] mem_read_data;
    logic        read_miss;
    logic        read_ready;
    logic        write_through;
    logic        write_ready;

    logic [31:0] mem [64];
    int          n_assert;
    int          n_fail;

    data_cache #(.NUM_SETS(8), .INDEX_BITS(3)) dut (
        .Clk             (clk),
        .Rst             (rst),
        .Address         (address),
        .MemRead         (mem_read),
        .MemWrite        (mem_write),
        .Write_data      (write_data),
        .Read_data       (read_data),
        .Stall           (stall),
        .Mem_Address     (mem_address),
        .Mem_Write_data  (mem_write_data),
        .Mem_Read_data   (mem_read_data),
        .ReadMiss        (read_miss),
        .ReadReady       (read_ready),
        .MemWriteThrough (write_through),
        .WriteReady      (write_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] block_of(input logic [31:0] a);
        int w;
        w = int'(a[7:3]) * 2;
        return {mem[w+1], mem[w]};
    endfunction

    // Respond to a pending fill after `lat` cycles; returns on the cycle after install.
    task automatic serve_fill(input int lat);
        for (int i = 0; i < lat; i++) tick();
        mem_read_data = block_of(mem_address);
        read_ready    = 1'b1;
        tick();
        read_ready    = 1'b0;
        mem_read_data = 64'h0;
    endtask

    // Complete a pending write-through, storing the block into the model.
    task automatic serve_write();
        int w;
        w = int'(mem_address[7:3]) * 2;
        mem[w]      = mem_write_data[31:0];
        mem[w+1]    = mem_write_data[63:32];
        write_ready = 1'b1;
        #1;
        chk("write_stall_release", {63'h0, stall}, 64'h0);
        tick();
        write_ready = 1'b0;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        for (int i = 0; i < 64; i++) mem[i] = i;
        rst = 1'b1; address = 32'h0; mem_read = 1'b0; mem_write = 1'b0;
        write_data = 32'h0; mem_read_data = 64'h0; read_ready = 1'b0; write_ready = 1'b0;

        // Reset state
        #3;
        chk("rst_read_miss",  {63'h0, read_miss}, 64'h0);
        chk("rst_write_thru", {63'h0, write_through}, 64'h0);
        chk("rst_mem_wdata",  mem_write_data, 64'h0);
        chk("rst_read_data",  {32'h0, read_data}, 64'h0);
        chk("rst_stall",      {63'h0, stall}, 64'h0);
        tick();
        tick();
        rst = 1'b0;

        // 1: cold load miss at 0x10
        tick();
        address = 32'h10; mem_read = 1'b1;
        #1;
        chk("t1_stall_miss", {63'h0, stall}, 64'h1);
        chk("t1_rm_not_yet", {63'h0, read_miss}, 64'h0);
        tick();
        chk("t1_read_miss", {63'h0, read_miss}, 64'h1);
        chk("t1_mem_addr",  {32'h0, mem_address}, 64'h10);
        serve_fill(1);
        chk("t1_rm_drop", {63'h0, read_miss}, 64'h0);
        chk("t1_stall",   {63'h0, stall}, 64'h0);
        chk("t1_data",    {32'h0, read_data}, 64'h4);

        // 2: neighbouring word hits
        tick();
        address = 32'h14;
        #1;
        chk("t2_stall", {63'h0, stall}, 64'h0);
        chk("t2_data",  {32'h0, read_data}, 64'h5);
        chk("t2_rm",    {63'h0, read_miss}, 64'h0);

        // Stray ready pulses in IDLE must not disturb anything
        read_ready = 1'b1; write_ready = 1'b1;
        tick();
        read_ready = 1'b0; write_ready = 1'b0;
        #1;
        chk("stray_rm",   {63'h0, read_miss}, 64'h0);
        chk("stray_data", {32'h0, read_data}, 64'h5);

        // 3: store hit, write-through of merged block
        tick();
        mem_read = 1'b0; mem_write = 1'b1; write_data = 32'hDEADBEEF;
        #1;
        chk("t3_stall", {63'h0, stall}, 64'h1);
        tick();
        chk("t3_wt",       {63'h0, write_through}, 64'h1);
        chk("t3_wdata",    mem_write_data, 64'hDEADBEEF_00000004);
        chk("t3_mem_addr", {32'h0, mem_address}, 64'h10);
        chk("t3_stall_wt", {63'h0, stall}, 64'h1);
        serve_write();
        mem_write = 1'b0; mem_read = 1'b1;
        #1;
        chk("t3_wt_drop", {63'h0, write_through}, 64'h0);
        chk("t3_reload",  {32'h0, read_data}, 64'hDEADBEEF);
        chk("t3_stall_0", {63'h0, stall}, 64'h0);

        // 4: conflict miss on index 2, then reload of the evicted block
        tick();
        address = 32'h50;
        #1;
        chk("t4_stall",     {63'h0, stall}, 64'h1);
        chk("t4_data_miss", {32'h0, read_data}, 64'h0);
        tick();
        chk("t4_mem_addr", {32'h0, mem_address}, 64'h50);
        serve_fill(0);
        chk("t4_data", {32'h0, read_data}, 64'h14);
        tick();
        address = 32'h10;
        #1;
        chk("t4_evicted", {63'h0, stall}, 64'h1);
        tick();
        chk("t4_rm2",    {63'h0, read_miss}, 64'h1);
        chk("t4_maddr2", {32'h0, mem_address}, 64'h10);
        serve_fill(2);
        chk("t4_data2", {32'h0, read_data}, 64'h4);

        // 5: store cold miss -> fill, merge, write-through
        tick();
        mem_read = 1'b0; mem_write = 1'b1; address = 32'h88; write_data = 32'h12345678;
        #1;
        chk("t5_stall", {63'h0, stall}, 64'h1);
        tick();
        chk("t5_rm",       {63'h0, read_miss}, 64'h1);
        chk("t5_mem_addr", {32'h0, mem_address}, 64'h88);
        serve_fill(1);
        chk("t5_rm_drop", {63'h0, read_miss}, 64'h0);
        chk("t5_wt",      {63'h0, write_through}, 64'h1);
        chk("t5_wdata",   mem_write_data, 64'h00000023_12345678);
        chk("t5_stall_w", {63'h0, stall}, 64'h1);
        serve_write();
        mem_write = 1'b0; mem_read = 1'b1;
        chk("t5_mem22", {32'h0, mem[34]}, 64'h12345678);
        chk("t5_mem23", {32'h0, mem[35]}, 64'h23);
        #1;
        chk("t5_hit_w0", {32'h0, read_data}, 64'h12345678);
        tick();
        address = 32'h8C;
        #1;
        chk("t5_hit_w1", {32'h0, read_data}, 64'h23);
        chk("t5_stall0", {63'h0, stall}, 64'h0);

        // 6: reset during a fill
        tick();
        address = 32'h20;
        tick();
        chk("t6_rm_pre", {63'h0, read_miss}, 64'h1);
        rst = 1'b1;
        #1;
        chk("t6_rm_async", {63'h0, read_miss}, 64'h0);
        chk("t6_wt_async", {63'h0, write_through}, 64'h0);
        tick();
        rst = 1'b0; address = 32'h14;
        #1;
        chk("t6_invalid", {63'h0, stall}, 64'h1);
        chk("t6_data0",   {32'h0, read_data}, 64'h0);
        tick();
        chk("t6_rm", {63'h0, read_miss}, 64'h1);
        serve_fill(1);
        chk("t6_data", {32'h0, read_data}, 64'hDEADBEEF);
        mem_read = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
